// File: rtl/kong_pkg.sv
// kong_pkg
//   Encodings and timing constants shared by the Kong game-logic controller and
//   the Kong sprite renderer. It carries the game state values, the throw
//   animation phase values, the phase lengths in frames and the pacing geometry.
package kong_pkg;

  // Game state encoding (1 bit).
  localparam logic [0:0] KONG_INITIAL = 1'b0;
  localparam logic [0:0] KONG_PLAYING = 1'b1;

  // Throw animation phase encoding (2 bits).
  localparam logic [1:0] KONG_NORMAL = 2'b00;
  localparam logic [1:0] KONG_GET    = 2'b01;
  localparam logic [1:0] KONG_HOLD   = 2'b10;
  localparam logic [1:0] KONG_DROP   = 2'b11;

  // Phase lengths in frames.
  localparam int NORMAL_FRAMES = 120;
  localparam int GET_FRAMES    = 20;
  localparam int HOLD_FRAMES   = 30;
  localparam int DROP_FRAMES   = 15;

  // Frame-counter width and the last count of each phase.
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] NORMAL_LAST = CNT_W'(NORMAL_FRAMES - 1);
  localparam logic [CNT_W-1:0] GET_LAST    = CNT_W'(GET_FRAMES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_FRAMES - 1);
  localparam logic [CNT_W-1:0] DROP_LAST   = CNT_W'(DROP_FRAMES - 1);

  // Position geometry (sprite centre).
  localparam int X_INIT = 100;
  localparam int Y_INIT = 80;
  localparam int X_MIN  = 80;
  localparam int X_MAX  = 160;
  localparam int X_STEP = 2;

  // Seed loaded into the random-delay LFSR on reset.
  localparam logic [7:0] LFSR_SEED = 8'hA5;

endpackage

// File: rtl/kong_lfsr.sv
// kong_lfsr
//   8-bit Fibonacci LFSR (taps 8,6,5,4) used to randomise the NORMAL phase
//   length. Built only when KONG_RANDOM_DELAY_EN is defined.
// Ports
//   clk   in  1  system clock
//   rst   in  1  synchronous reset, active-high; loads seed
//   en    in  1  advance one step this cycle
//   seed  in  8  value loaded on reset
//   q     out 8  current LFSR state
`ifdef KONG_RANDOM_DELAY_EN
module kong_lfsr (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  logic feedback;

  // Taps 8,6,5,4 map to bits 7,5,4,3; the new bit shifts in at the LSB.
  assign feedback = q[7] ^ q[5] ^ q[4] ^ q[3];

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= seed;
    end else if (en) begin
      q <= {q[6:0], feedback};
    end
  end

endmodule
`endif

// File: rtl/kong_controller.sv
// kong_controller
//   Donkey Kong game-logic FSM. Tracks the game state, runs the four-phase
//   throw animation (NORMAL -> GET -> HOLD -> DROP), paces Kong horizontally
//   during NORMAL and raises a barrel-spawn request at the start of DROP.
//   All outputs are registered and feed the sprite renderer directly.
// Configuration
//   KONG_RANDOM_DELAY_EN: when defined, each NORMAL phase is lengthened by a
//   0..63 frame value latched from an 8-bit LFSR on NORMAL entry. When
//   undefined, NORMAL lasts exactly NORMAL_FRAMES and no LFSR is built.
// Ports
//   clk              in   1   system clock
//   rst              in   1   synchronous reset, active-high
//   start            in   1   level; INITIAL -> PLAYING
//   game_over        in   1   level; return to the reset state (beats start)
//   frame_tick       in   1   one-cycle pulse per video frame
//   barrel_ack       in   1   spawner accepted the barrel
//   state            out  1   KONG_INITIAL / KONG_PLAYING
//   animation_state  out  2   KONG_NORMAL / GET / HOLD / DROP
//   posX             out  10  Kong centre X
//   posY             out  9   Kong centre Y
//   barrel_req       out  1   held high until acknowledged
module kong_controller
  import kong_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       game_over,
  input  logic       frame_tick,
  input  logic       barrel_ack,
  output logic       state,
  output logic [1:0] animation_state,
  output logic [9:0] posX,
  output logic [8:0] posY,
  output logic       barrel_req
);

  localparam logic signed [10:0] X_MIN_S  = signed'(11'(X_MIN));
  localparam logic signed [10:0] X_MAX_S  = signed'(11'(X_MAX));
  localparam logic signed [10:0] X_STEP_S = signed'(11'(X_STEP));

  // Registered state and its next-state values.
  logic             state_q,   state_d;
  logic [1:0]       anim_q,    anim_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [9:0]       pos_x_q,   pos_x_d;
  logic [8:0]       pos_y_q;
  logic             dir_neg_q, dir_neg_d;   // 0 = moving +X, 1 = moving -X
  logic             req_q,     req_d;

  logic             req_clear;
  logic signed [10:0] x_sum;
  logic [CNT_W-1:0] normal_last;

  // An acknowledge only counts while a request is outstanding.
  assign req_clear = req_q & barrel_ack;

  // Pacing sum in 11-bit signed so a step below zero or past 1023 cannot wrap
  // into a value that passes the bounds check.
  assign x_sum = signed'({1'b0, pos_x_q}) + (dir_neg_q ? -X_STEP_S : X_STEP_S);

`ifdef KONG_RANDOM_DELAY_EN
  logic [7:0] lfsr_q;
  logic [5:0] extra_q;
  logic       normal_entry;

  kong_lfsr u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .en   (1'b1),
    .seed (LFSR_SEED),
    .q    (lfsr_q)
  );

  // NORMAL is entered either by starting play or by finishing a DROP.
  assign normal_entry = (state_d == KONG_PLAYING) && (anim_d == KONG_NORMAL) &&
                        ((state_q == KONG_INITIAL) || (anim_q == KONG_DROP));

  always_ff @(posedge clk) begin
    if (rst) begin
      extra_q <= '0;
    end else if (normal_entry) begin
      extra_q <= lfsr_q[5:0];
    end
  end

  assign normal_last = NORMAL_LAST + {2'b00, extra_q};
`else
  assign normal_last = NORMAL_LAST;
`endif

  // NOTE: every signal driven here gets a default at the top of the block, so
  // no path through the case/if tree can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    anim_d    = anim_q;
    cnt_d     = cnt_q;
    pos_x_d   = pos_x_q;
    dir_neg_d = dir_neg_q;
    req_d     = req_q;

    if (game_over) begin
      // Same values as reset; a pending request is dropped and ack ignored.
      state_d   = KONG_INITIAL;
      anim_d    = KONG_NORMAL;
      cnt_d     = '0;
      pos_x_d   = 10'(X_INIT);
      dir_neg_d = 1'b0;
      req_d     = 1'b0;
    end else if (state_q == KONG_INITIAL) begin
      if (start) begin
        state_d = KONG_PLAYING;
        cnt_d   = '0;
      end
    end else begin
      if (req_clear) begin
        req_d = 1'b0;
      end

      if (frame_tick) begin
        case (anim_q)
          KONG_NORMAL: begin
            if (x_sum > X_MAX_S) begin
              pos_x_d   = 10'(X_MAX);
              dir_neg_d = 1'b1;
            end else if (x_sum < X_MIN_S) begin
              pos_x_d   = 10'(X_MIN);
              dir_neg_d = 1'b0;
            end else begin
              pos_x_d = x_sum[9:0];
            end

            if (cnt_q == normal_last) begin
              anim_d = KONG_GET;
              cnt_d  = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end

          KONG_GET: begin
            if (cnt_q == GET_LAST) begin
              anim_d = KONG_HOLD;
              cnt_d  = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end

          KONG_HOLD: begin
            if (cnt_q == HOLD_LAST) begin
              anim_d = KONG_DROP;
              cnt_d  = '0;
              req_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end

          default: begin  // KONG_DROP
            if (cnt_q == DROP_LAST) begin
              // Leave only once the barrel is taken (or is being taken now);
              // otherwise park the counter at its last value.
              if (!req_q || req_clear) begin
                anim_d = KONG_NORMAL;
                cnt_d  = '0;
              end else begin
                cnt_d = DROP_LAST;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= KONG_INITIAL;
      anim_q    <= KONG_NORMAL;
      cnt_q     <= '0;
      pos_x_q   <= 10'(X_INIT);
      pos_y_q   <= 9'(Y_INIT);
      dir_neg_q <= 1'b0;
      req_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      anim_q    <= anim_d;
      cnt_q     <= cnt_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= 9'(Y_INIT);
      dir_neg_q <= dir_neg_d;
      req_q     <= req_d;
    end
  end

  assign state           = state_q;
  assign animation_state = anim_q;
  assign posX            = pos_x_q;
  assign posY            = pos_y_q;
  assign barrel_req      = req_q;

endmodule

// File: tb/tb_kong_controller.sv
// tb_kong_controller
//   Directed bench for kong_controller in its default build (fixed NORMAL
//   length). Inputs change on the falling edge; outputs are sampled on the
//   falling edge after the rising edge that consumed them.
module tb_kong_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       game_over;
  logic       frame_tick;
  logic       barrel_ack;
  logic       state;
  logic [1:0] animation_state;
  logic [9:0] posX;
  logic [8:0] posY;
  logic       barrel_req;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  kong_controller dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .game_over       (game_over),
    .frame_tick      (frame_tick),
    .barrel_ack      (barrel_ack),
    .state           (state),
    .animation_state (animation_state),
    .posX            (posX),
    .posY            (posY),
    .barrel_req      (barrel_req)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // n frame ticks, each a one-cycle pulse followed by an idle cycle.
  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) frame_tick = 1'b1;
      @(negedge clk) frame_tick = 1'b0;
    end
  endtask

  task automatic ack_pulse();
    @(negedge clk) barrel_ack = 1'b1;
    @(negedge clk) barrel_ack = 1'b0;
  endtask

  task automatic start_pulse();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; game_over = 1'b0; frame_tick = 1'b0; barrel_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset values.
    check("rst_state", state, 0);
    check("rst_anim",  animation_state, 0);
    check("rst_posx",  posX, 100);
    check("rst_posy",  posY, 80);
    check("rst_req",   barrel_req, 0);

    // Ticks in INITIAL must not move anything.
    tick_n(3);
    check("init_hold_posx", posX, 100);

    start_pulse();
    check("start_state", state, 1);
    check("start_anim",  animation_state, 0);
    check("start_posx",  posX, 100);
    check("start_posy",  posY, 80);

    // Pacing: 100 + 30*2 = 160; tick 31 clamps at 160 and turns; tick 32 -> 158.
    tick_n(30);
    check("pace_30_posx", posX, 160);
    tick_n(1);
    check("pace_31_posx", posX, 160);
    tick_n(1);
    check("pace_32_posx", posX, 158);

    // Tick 71 reaches 80, 72 clamps at 80 and turns, 112 reaches 160,
    // 113 clamps and turns, 119 -> 148, 120 -> 146.
    tick_n(87);
    check("normal_119_anim", animation_state, 0);
    check("normal_119_posx", posX, 148);
    tick_n(1);
    check("get_anim",  animation_state, 1);
    check("get_posx",  posX, 146);

    tick_n(19);
    check("get_19_anim", animation_state, 1);
    tick_n(1);
    check("hold_anim", animation_state, 2);
    check("hold_req",  barrel_req, 0);

    tick_n(29);
    check("hold_29_anim", animation_state, 2);
    tick_n(1);
    check("drop_anim", animation_state, 3);
    check("drop_req",  barrel_req, 1);
    check("drop_posx", posX, 146);

    // Ack withheld: DROP persists and the request stays up.
    tick_n(40);
    check("drop_wait_anim", animation_state, 3);
    check("drop_wait_req",  barrel_req, 1);
    ack_pulse();
    check("ack_req",  barrel_req, 0);
    check("ack_anim", animation_state, 3);
    tick_n(1);
    check("drop_exit_anim", animation_state, 0);
    check("drop_exit_posx", posX, 146);

    // Pacing resumes downwards; ack with no request pending is ignored.
    tick_n(1);
    check("resume_posx", posX, 144);
    ack_pulse();
    check("stray_ack_req", barrel_req, 0);

    // Second throw: NORMAL already has 1 tick, 119 more reach GET.
    tick_n(118);
    check("n2_119_anim", animation_state, 0);
    tick_n(1 + 20 + 30);
    check("d2_anim", animation_state, 3);
    check("d2_req",  barrel_req, 1);
    tick_n(14);
    check("d2_14_anim", animation_state, 3);
    // Ack on the same edge as the final DROP tick lets DROP end immediately.
    @(negedge clk) begin frame_tick = 1'b1; barrel_ack = 1'b1; end
    @(negedge clk) begin frame_tick = 1'b0; barrel_ack = 1'b0; end
    check("d2_exit_anim", animation_state, 0);
    check("d2_exit_req",  barrel_req, 0);

    // Third throw, then game_over together with ack while the request is up.
    tick_n(120 + 20 + 30 + 5);
    check("d3_anim", animation_state, 3);
    check("d3_req",  barrel_req, 1);
    @(negedge clk) begin game_over = 1'b1; barrel_ack = 1'b1; end
    @(negedge clk) begin game_over = 1'b0; barrel_ack = 1'b0; end
    check("go_state", state, 0);
    check("go_anim",  animation_state, 0);
    check("go_req",   barrel_req, 0);
    check("go_posx",  posX, 100);

    // game_over wins over start.
    @(negedge clk) begin game_over = 1'b1; start = 1'b1; end
    @(negedge clk) begin game_over = 1'b0; start = 1'b0; end
    check("go_start_state", state, 0);

    // Direction was reset to +X.
    start_pulse();
    check("restart_state", state, 1);
    tick_n(1);
    check("restart_posx", posX, 102);

    // rst beats a simultaneous start.
    @(negedge clk) begin rst = 1'b1; start = 1'b1; end
    @(negedge clk) begin rst = 1'b0; start = 1'b0; end
    check("rst_start_state", state, 0);
    check("rst_start_posx",  posX, 100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
